lcd_update_sequencer: RTL and testbench

//  Drives the HD44780-style character LCD bus (rs/rw/en/data) for the temperature display.

---
 rtl/lcd_update_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_update_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_update_sequencer.sv
// lcd_update_sequencer: HD44780 write-only bus driver. Runs the power-up/init sequence,
// then shows each new temperature byte as cursor-home plus three ASCII decimal digits.
`default_nettype none

module lcd_update_sequencer #(
   parameter int PWRUP_WAIT = 750000,
   parameter int EN_SETUP   = 2,
   parameter int EN_WIDTH   = 12,
   parameter int CMD_WAIT   = 2000,
   parameter int CLR_WAIT   = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value,
   input  logic       value_valid,
   output logic       rs,
   output logic       rw,
   output logic       en,
   output logic [7:0] data,
   output logic       init_done,
   output logic       busy
);

   localparam int MAXP01 = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
   localparam int MAXP02 = (MAXP01 > CMD_WAIT) ? MAXP01 : CMD_WAIT;
   localparam int MAXP03 = (MAXP02 > EN_WIDTH) ? MAXP02 : EN_WIDTH;
   localparam int MAXP   = (MAXP03 > EN_SETUP) ? MAXP03 : EN_SETUP;
   localparam int CW     = $clog2(MAXP + 1);

   typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_UPDATE} state_t;
   typedef enum logic [1:0] {B_SETUP, B_PULSE, B_WAIT} bstate_t;

   state_t        state_q, state_d;
   bstate_t       bstate_q, bstate_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          rs_q, rs_d;
   logic          en_q, en_d;
   logic [7:0]    data_q, data_d;
   logic          init_done_q, init_done_d;
   logic          busy_q, busy_d;
   logic          pend_q, pend_d;
   logic [7:0]    pend_val_q, pend_val_d;
   logic [3:0]    hun_q, hun_d, ten_q, ten_d, one_q, one_d;

   logic [7:0]    cap;
   logic [1:0]    nidx;
   logic [8:0]    nbyte;
   logic [CW-1:0] wait_last;

   // {rs, data} for byte i of the init or update sequence
   function automatic logic [8:0] byte_sel(input logic upd, input logic [1:0] i,
                                           input logic [3:0] h, input logic [3:0] t,
                                           input logic [3:0] o);
      logic [8:0] r;
      r = 9'h000;
      if (!upd) begin
         case (i)
            2'd0:    r = {1'b0, 8'h38};
            2'd1:    r = {1'b0, 8'h0C};
            2'd2:    r = {1'b0, 8'h01};
            default: r = {1'b0, 8'h06};
         endcase
      end else begin
         case (i)
            2'd0:    r = {1'b0, 8'h80};
            2'd1:    r = {1'b1, 4'h3, h};
            2'd2:    r = {1'b1, 4'h3, t};
            default: r = {1'b1, 4'h3, o};
         endcase
      end
      return r;
   endfunction

   assign cap       = pend_q ? pend_val_q : value;
   assign nidx      = idx_q + 2'd1;
   assign nbyte     = byte_sel(state_q == ST_UPDATE, nidx, hun_q, ten_q, one_q);
   assign wait_last = (data_q == 8'h01) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);

   always_comb begin
      state_d     = state_q;
      bstate_d    = bstate_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      rs_d        = rs_q;
      en_d        = en_q;
      data_d      = data_q;
      init_done_d = init_done_q;
      busy_d      = busy_q;
      hun_d       = hun_q;
      ten_d       = ten_q;
      one_d       = one_q;

      case (state_q)
         ST_PWRUP: begin
            if (cnt_q == CW'(PWRUP_WAIT - 1)) begin
               state_d  = ST_INIT;
               bstate_d = B_SETUP;
               cnt_d    = '0;
               idx_d    = 2'd0;
               rs_d     = 1'b0;
               data_d   = 8'h38;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            busy_d = 1'b0;
            if (pend_q || value_valid) begin
               state_d  = ST_UPDATE;
               bstate_d = B_SETUP;
               busy_d   = 1'b1;
               cnt_d    = '0;
               idx_d    = 2'd0;
               rs_d     = 1'b0;
               data_d   = 8'h80;
               hun_d    = 4'(cap / 8'd100);
               ten_d    = 4'((cap / 8'd10) % 8'd10);
               one_d    = 4'(cap % 8'd10);
            end
         end
         default: begin
            // Byte sub-sequence shared by INIT and UPDATE
            case (bstate_q)
               B_SETUP: begin
                  if (cnt_q == CW'(EN_SETUP - 1)) begin
                     bstate_d = B_PULSE;
                     en_d     = 1'b1;
                     cnt_d    = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               B_PULSE: begin
                  if (cnt_q == CW'(EN_WIDTH - 1)) begin
                     bstate_d = B_WAIT;
                     en_d     = 1'b0;
                     cnt_d    = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: begin
                  if (cnt_q == wait_last) begin
                     cnt_d = '0;
                     if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        if (state_q == ST_INIT) init_done_d = 1'b1;
                     end else begin
                        idx_d    = nidx;
                        bstate_d = B_SETUP;
                        rs_d     = nbyte[8];
                        data_d   = nbyte[7:0];
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            endcase
         end
      endcase
   end

   // One-deep pending slot; a strobe coinciding with a pending capture is re-pended
   always_comb begin
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      if (value_valid && (state_q != ST_IDLE || pend_q)) begin
         pend_d     = 1'b1;
         pend_val_d = value;
      end else if (state_q == ST_IDLE && pend_q) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_PWRUP;
         bstate_q    <= B_SETUP;
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         rs_q        <= 1'b0;
         en_q        <= 1'b0;
         data_q      <= 8'h00;
         init_done_q <= 1'b0;
         busy_q      <= 1'b1;
         pend_q      <= 1'b0;
         pend_val_q  <= 8'h00;
         hun_q       <= 4'h0;
         ten_q       <= 4'h0;
         one_q       <= 4'h0;
      end else begin
         state_q     <= state_d;
         bstate_q    <= bstate_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         rs_q        <= rs_d;
         en_q        <= en_d;
         data_q      <= data_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
         pend_q      <= pend_d;
         pend_val_q  <= pend_val_d;
         hun_q       <= hun_d;
         ten_q       <= ten_d;
         one_q       <= one_d;
      end
   end

   assign rs        = rs_q;
   assign rw        = 1'b0;
   assign en        = en_q;
   assign data      = data_q;
   assign init_done = init_done_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_update_sequencer.sv
// tb_lcd_update_sequencer: directed bench with a vector table of display updates
// and hand-written sequences for reset, init timing and pending-value handling.
`default_nettype none

module tb_lcd_update_sequencer;

   localparam int PW   = 20;
   localparam int ES   = 2;
   localparam int EW   = 3;
   localparam int CMDW = 5;
   localparam int CLRW = 9;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] value = 8'h00;
   logic       value_valid = 1'b0;
   logic       rs, rw, en, init_done, busy;
   logic [7:0] data;

   int n_checks = 0;
   int n_fail   = 0;

   lcd_update_sequencer #(
      .PWRUP_WAIT(PW), .EN_SETUP(ES), .EN_WIDTH(EW), .CMD_WAIT(CMDW), .CLR_WAIT(CLRW)
   ) dut (
      .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
      .rs(rs), .rw(rw), .en(en), .data(data), .init_done(init_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         width;
      int         gap;
   } rec_t;

   typedef struct {
      logic [7:0] v;
      logic [7:0] d1;
      logic [7:0] d2;
      logic [7:0] d3;
   } vec_t;

   rec_t q[$];
   int   lowcnt   = 0;
   int   unstable = 0;

   // Bus monitor: one record per en pulse (value, high width, preceding low stretch)
   initial begin
      rec_t cur;
      int   highcnt;
      logic en_prev;
      en_prev = 1'b0;
      highcnt = 0;
      cur     = '{rs: 1'b0, data: 8'h00, width: 0, gap: 0};
      forever begin
         @(negedge clk);
         if (!rst) begin
            q.delete();
            lowcnt  = 0;
            highcnt = 0;
            en_prev = 1'b0;
         end else if (en && !en_prev) begin
            cur.rs   = rs;
            cur.data = data;
            cur.gap  = lowcnt;
            highcnt  = 1;
            en_prev  = 1'b1;
         end else if (en) begin
            highcnt++;
            if (rs !== cur.rs || data !== cur.data) unstable++;
         end else if (en_prev) begin
            cur.width = highcnt;
            q.push_back(cur);
            lowcnt  = 1;
            en_prev = 1'b0;
         end else begin
            lowcnt++;
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_busy_low(input string nm);
      int n = 0;
      while (busy !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      check({nm, "_busy_timeout"}, int'(busy === 1'b0), 1);
   endtask

   task automatic wait_init_done(input string nm);
      int n = 0;
      while (init_done !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
      check({nm, "_init_timeout"}, int'(init_done === 1'b1), 1);
   endtask

   task automatic check_rec(input string nm, input int i, input logic exp_rs, input logic [7:0] exp_d);
      if (i < q.size()) begin
         check({nm, "_data"}, int'(q[i].data), int'(exp_d));
         check({nm, "_rs"}, int'(q[i].rs), int'(exp_rs));
         check({nm, "_width"}, q[i].width, EW);
      end else begin
         check({nm, "_missing"}, 0, 1);
      end
   endtask

   task automatic check_update(input string nm, input int base, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
      check_rec({nm, "_home"}, base, 1'b0, 8'h80);
      check_rec({nm, "_hun"}, base + 1, 1'b1, d1);
      check_rec({nm, "_ten"}, base + 2, 1'b1, d2);
      check_rec({nm, "_one"}, base + 3, 1'b1, d3);
   endtask

   task automatic check_init(input string nm);
      check_rec({nm, "_b0"}, 0, 1'b0, 8'h38);
      check_rec({nm, "_b1"}, 1, 1'b0, 8'h0C);
      check_rec({nm, "_b2"}, 2, 1'b0, 8'h01);
      check_rec({nm, "_b3"}, 3, 1'b0, 8'h06);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      int   n;
      vt[0] = '{v: 8'd123, d1: 8'h31, d2: 8'h32, d3: 8'h33};
      vt[1] = '{v: 8'd0,   d1: 8'h30, d2: 8'h30, d3: 8'h30};
      vt[2] = '{v: 8'd255, d1: 8'h32, d2: 8'h35, d3: 8'h35};
      vt[3] = '{v: 8'd7,   d1: 8'h30, d2: 8'h30, d3: 8'h37};
      vt[4] = '{v: 8'd100, d1: 8'h31, d2: 8'h30, d3: 8'h30};
      vt[5] = '{v: 8'd59,  d1: 8'h30, d2: 8'h35, d3: 8'h39};

      // Start, reach the first en pulse, then reset in the middle of it
      repeat (3) tick();
      @(posedge clk);
      #3 rst = 1'b1;
      n = 0;
      while (en !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("first_pulse_seen", int'(en === 1'b1), 1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_en_async", int'(en), 0);
      check("rst_rs", int'(rs), 0);
      check("rst_rw", int'(rw), 0);
      check("rst_data", int'(data), 0);
      check("rst_init_done", int'(init_done), 0);
      check("rst_busy", int'(busy), 1);

      tick();
      tick();
      @(posedge clk);
      #3 rst = 1'b1;
      n = 0;
      while (en !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("first_en_latency", n, PW + ES);

      wait_init_done("init");
      check("init_busy_low", int'(busy), 0);
      check("init_last_wait", lowcnt, CMDW);
      check("init_count", q.size(), 4);
      check_init("init");
      if (q.size() >= 4) begin
         check("gap_after_38", q[1].gap, CMDW + ES);
         check("gap_after_0c", q[2].gap, CMDW + ES);
         check("gap_after_01", q[3].gap, CLRW + ES);
      end

      // Table of single updates from IDLE
      foreach (vt[i]) begin
         q.delete();
         value       = vt[i].v;
         value_valid = 1'b1;
         tick();
         value_valid = 1'b0;
         check($sformatf("v%0d_busy_start", vt[i].v), int'(busy), 1);
         wait_busy_low($sformatf("v%0d", vt[i].v));
         check($sformatf("v%0d_count", vt[i].v), q.size(), 4);
         check($sformatf("v%0d_rw", vt[i].v), int'(rw), 0);
         check_update($sformatf("v%0d", vt[i].v), 0, vt[i].d1, vt[i].d2, vt[i].d3);
      end

      // Two strobes during an update: only the latest survives
      q.delete();
      value       = 8'd10;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      repeat (8) tick();
      value       = 8'd42;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      repeat (6) tick();
      value       = 8'd99;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      value       = 8'hAA;
      wait_busy_low("inflight_first");
      tick();
      check("inflight_rebusy", int'(busy), 1);
      wait_busy_low("inflight_second");
      check("inflight_count", q.size(), 8);
      check_update("inflight_10", 0, 8'h30, 8'h31, 8'h30);
      check_update("inflight_99", 4, 8'h30, 8'h39, 8'h39);

      // Strobe during INIT is held until init completes
      @(posedge clk);
      #2 rst = 1'b0;
      tick();
      @(posedge clk);
      #3 rst = 1'b1;
      repeat (25) tick();
      value       = 8'd56;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      value       = 8'h00;
      wait_init_done("initpend");
      tick();
      check("initpend_busy", int'(busy), 1);
      wait_busy_low("initpend");
      check("initpend_count", q.size(), 8);
      check_init("initpend");
      check_update("initpend_56", 4, 8'h30, 8'h35, 8'h36);
      if (q.size() >= 5) check("initpend_gap", q[4].gap, CMDW + 1 + ES);
      check("pulse_stable", unstable, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
